// File: rtl/fetch_unit.sv
// Sequential instruction fetch from a one-cycle-latency block RAM with redirect,
// a registered output stage and a one-entry skid buffer for downstream stalls.
module fetch_unit #(
    parameter logic [15:0] reset_pc  = 16'h0000,
    parameter int unsigned adr_width = 11
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic [15:0] mem_a,
    output logic        mem_we,
    output logic [15:0] mem_do,
    input  logic [15:0] mem_di,
    input  logic        br_valid,
    input  logic [15:0] br_target,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned PC_W = 16;

    typedef struct packed {
        logic            v;
        logic [PC_W-1:0] instr;
        logic [PC_W-1:0] pc;
    } slot_t;

    // adr_width only documents the RAM depth; an out-of-range value is flagged in the hierarchy
    if (adr_width == 0 || adr_width > PC_W) begin : g_adr_width_out_of_range
    end

    logic [PC_W-1:0] pc_q, pc_n;
    logic            inf_v_q, inf_v_n;
    logic [PC_W-1:0] inf_pc_q, inf_pc_n;
    slot_t           out_q, out_n;
    slot_t           skid_q, skid_n;

    logic [1:0]      cnt_c;
    logic            deq_c;
    logic            issue_c;

    assign mem_we      = 1'b0;
    assign mem_do      = 16'h0000;
    assign instr_valid = out_q.v;
    assign instr       = out_q.instr;
    assign instr_pc    = out_q.pc;

    // Issue decision, RAM address and buffer steering
    always_comb begin
        cnt_c    = 2'(out_q.v) + 2'(skid_q.v) + 2'(inf_v_q);
        deq_c    = out_q.v & instr_ready;
        issue_c  = !sys_rst && (br_valid || ((cnt_c - 2'(deq_c)) <= 2'd1));
        mem_a    = br_valid ? br_target : pc_q;

        pc_n     = pc_q;
        inf_v_n  = issue_c;
        inf_pc_n = inf_pc_q;
        out_n    = out_q;
        skid_n   = skid_q;

        if (issue_c) begin
            inf_pc_n = mem_a;
            pc_n     = mem_a + PC_W'(1);
        end

        if (deq_c) begin
            if (skid_q.v) begin
                out_n    = skid_q;
                skid_n.v = 1'b0;
            end else begin
                out_n.v  = 1'b0;
            end
        end

        // Returning word goes to the output stage if it frees up, otherwise to skid
        if (inf_v_q) begin
            if (!out_n.v) begin
                out_n  = '{v: 1'b1, instr: mem_di, pc: inf_pc_q};
            end else begin
                skid_n = '{v: 1'b1, instr: mem_di, pc: inf_pc_q};
            end
        end

        if (br_valid) begin
            out_n.v  = 1'b0;
            skid_n.v = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pc_q     <= reset_pc;
            inf_v_q  <= 1'b0;
            inf_pc_q <= '0;
            out_q    <= '0;
            skid_q   <= '0;
        end else begin
            pc_q     <= pc_n;
            inf_v_q  <= inf_v_n;
            inf_pc_q <= inf_pc_n;
            out_q    <= out_n;
            skid_q   <= skid_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a long randomized
// run compared against an expected-address stream model.
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [15:0] mem_a;
    logic        mem_we;
    logic [15:0] mem_do;
    logic [15:0] mem_di = 16'h0000;
    logic        br_valid = 1'b0;
    logic [15:0] br_target = 16'h0000;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(.reset_pc(RESET_PC), .adr_width(11)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .mem_a      (mem_a),
        .mem_we     (mem_we),
        .mem_do     (mem_do),
        .mem_di     (mem_di),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] ram_f(input logic [15:0] a);
        return 16'(16'hA000 + a);
    endfunction

    // Block RAM model: data valid the cycle after its address
    always @(posedge sys_clk) mem_di <= ram_f(mem_a);

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst     = 1'b1;
        br_valid    = 1'b0;
        instr_ready = 1'b1;
        next_cycle();
        sys_rst     = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst     = 1'b1;
        br_valid    = 1'b1;
        br_target   = 16'h5555;
        instr_ready = 1'b1;
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (instr_valid !== 1'b0 || instr !== 16'h0000 || instr_pc !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_outputs: got v=%b instr=%h pc=%h, want 0/0000/0000",
                         instr_valid, instr, instr_pc);
            end
            n_cmp++;
            if (mem_we !== 1'b0 || mem_do !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_mem_we: got we=%b do=%h, want 0/0000", mem_we, mem_do);
            end
            next_cycle();
        end
        sys_rst  = 1'b0;
        br_valid = 1'b0;
    endtask

    // Entered in the first cycle with sys_rst low
    task automatic test_stream();
        for (int c = 0; c < 10; c++) begin
            instr_ready = 1'b1;
            @(negedge sys_clk);
            n_cmp++;
            if (mem_a !== 16'(RESET_PC + 16'(c))) begin
                n_bad++;
                $display("FAIL stream_mem_a c=%0d: got %h want %h", c, mem_a, 16'(RESET_PC + 16'(c)));
            end
            n_cmp++;
            if (instr_valid !== (c >= 2)) begin
                n_bad++;
                $display("FAIL stream_valid c=%0d: got %b want %b", c, instr_valid, (c >= 2));
            end
            if (c >= 2) begin
                n_cmp++;
                if (instr_pc !== 16'(RESET_PC + 16'(c - 2)) || instr !== ram_f(16'(RESET_PC + 16'(c - 2)))) begin
                    n_bad++;
                    $display("FAIL stream_word c=%0d: got pc=%h instr=%h want pc=%h", c, instr_pc, instr,
                             16'(RESET_PC + 16'(c - 2)));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        logic [15:0] exp;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            instr_ready = !(c >= 5 && c <= 9);
            @(negedge sys_clk);
            if (c >= 5) begin
                exp = (c <= 10) ? 16'd3 : 16'(c - 7);
                n_cmp++;
                if (instr_valid !== 1'b1 || instr_pc !== exp || instr !== ram_f(exp)) begin
                    n_bad++;
                    $display("FAIL stall_word c=%0d: got v=%b pc=%h instr=%h want pc=%h instr=%h",
                             c, instr_valid, instr_pc, instr, exp, ram_f(exp));
                end
            end
            if (c >= 5 && c <= 10) begin
                n_cmp++;
                if (mem_a !== 16'd5) begin
                    n_bad++;
                    $display("FAIL stall_mem_a c=%0d: got %h want 0005", c, mem_a);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            instr_ready = !(c >= 4 && c <= 8);
            br_valid    = (c == 8);
            br_target   = 16'h0040;
            @(negedge sys_clk);
            if (c >= 4 && c <= 8) begin
                n_cmp++;
                if (instr_valid !== 1'b1 || instr_pc !== 16'd2) begin
                    n_bad++;
                    $display("FAIL branch_hold c=%0d: got v=%b pc=%h want 1/0002", c, instr_valid, instr_pc);
                end
            end
            if (c == 8) begin
                n_cmp++;
                if (mem_a !== 16'h0040) begin
                    n_bad++;
                    $display("FAIL branch_mem_a: got %h want 0040", mem_a);
                end
            end
            if (c == 9) begin
                n_cmp++;
                if (instr_valid !== 1'b0 || mem_a !== 16'h0041) begin
                    n_bad++;
                    $display("FAIL branch_flush: got v=%b mem_a=%h want 0/0041", instr_valid, mem_a);
                end
            end
            if (c >= 10) begin
                n_cmp++;
                if (instr_valid !== 1'b1 || instr_pc !== 16'(16'h0040 + 16'(c - 10)) ||
                    instr !== ram_f(16'(16'h0040 + 16'(c - 10)))) begin
                    n_bad++;
                    $display("FAIL branch_word c=%0d: got v=%b pc=%h instr=%h", c, instr_valid, instr_pc, instr);
                end
            end
            next_cycle();
        end
        br_valid = 1'b0;
    endtask

    task automatic test_wrap();
        logic [15:0] exp;
        for (int i = 0; i < 6; i++) begin
            instr_ready = 1'b1;
            br_valid    = (i == 0);
            br_target   = 16'hFFFE;
            @(negedge sys_clk);
            if (i == 1) begin
                n_cmp++;
                if (instr_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wrap_flush: got v=%b want 0", instr_valid);
                end
            end
            if (i >= 2) begin
                exp = 16'(16'hFFFE + 16'(i - 2));
                n_cmp++;
                if (instr_valid !== 1'b1 || instr_pc !== exp || instr !== ram_f(exp)) begin
                    n_bad++;
                    $display("FAIL wrap_word i=%0d: got v=%b pc=%h instr=%h want pc=%h", i, instr_valid,
                             instr_pc, instr, exp);
                end
            end
            next_cycle();
        end
        br_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            instr_ready = 1'b1;
            sys_rst     = (c == 6);
            br_valid    = (c == 6);
            br_target   = 16'h1234;
            @(negedge sys_clk);
            if (c == 7 || c == 8) begin
                exp = 16'(RESET_PC + 16'(c - 7));
                n_cmp++;
                if (instr_valid !== 1'b0 || mem_a !== exp) begin
                    n_bad++;
                    $display("FAIL rstmid_restart c=%0d: got v=%b mem_a=%h want 0/%h", c, instr_valid, mem_a, exp);
                end
            end
            if (c >= 9) begin
                exp = 16'(RESET_PC + 16'(c - 9));
                n_cmp++;
                if (instr_valid !== 1'b1 || instr_pc !== exp || instr !== ram_f(exp)) begin
                    n_bad++;
                    $display("FAIL rstmid_word c=%0d: got v=%b pc=%h instr=%h want pc=%h", c, instr_valid,
                             instr_pc, instr, exp);
                end
            end
            next_cycle();
        end
        sys_rst  = 1'b0;
        br_valid = 1'b0;
    endtask

    // Model: the accepted stream is a run of consecutive addresses restarting at each redirect
    task automatic test_random();
        logic [15:0] exp_pc;
        logic        prev_br;
        logic        prev_hold;
        logic [15:0] prev_instr;
        logic [15:0] prev_pc;
        int          idle;
        int          ready_pct;
        exp_pc     = 16'h0000;
        prev_br    = 1'b0;
        prev_hold  = 1'b0;
        prev_instr = 16'h0000;
        prev_pc    = 16'h0000;
        idle       = 0;
        ready_pct  = 90;
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) ready_pct = (c % 1500 == 0) ? 90 : ((c % 1500 == 500) ? 50 : 15);
            if (c == 0) begin
                instr_ready = 1'b0;
                br_valid    = 1'b1;
            end else begin
                instr_ready = ($urandom_range(0, 99) < ready_pct);
                br_valid    = ($urandom_range(0, 39) == 0);
            end
            br_target = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + 16'($urandom_range(0, 15)))
                                                    : 16'($urandom);
            @(negedge sys_clk);
            n_cmp++;
            if (mem_we !== 1'b0 || mem_do !== 16'h0000) begin
                n_bad++;
                $display("FAIL rand_mem_we c=%0d: got we=%b do=%h want 0/0000", c, mem_we, mem_do);
            end
            if (br_valid) begin
                n_cmp++;
                if (mem_a !== br_target) begin
                    n_bad++;
                    $display("FAIL rand_br_addr c=%0d: got %h want %h", c, mem_a, br_target);
                end
            end
            if (prev_br) begin
                n_cmp++;
                if (instr_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rand_flush c=%0d: got v=%b want 0", c, instr_valid);
                end
            end
            if (prev_hold) begin
                n_cmp++;
                if (instr_valid !== 1'b1 || instr !== prev_instr || instr_pc !== prev_pc) begin
                    n_bad++;
                    $display("FAIL rand_hold c=%0d: got v=%b pc=%h instr=%h want 1/%h/%h", c, instr_valid,
                             instr_pc, instr, prev_pc, prev_instr);
                end
            end
            if (instr_valid && instr_ready) begin
                n_cmp++;
                if (instr_pc !== exp_pc || instr !== ram_f(exp_pc)) begin
                    n_bad++;
                    $display("FAIL rand_order c=%0d: got pc=%h instr=%h want pc=%h instr=%h", c, instr_pc,
                             instr, exp_pc, ram_f(exp_pc));
                end
                exp_pc = 16'(exp_pc + 16'd1);
            end
            if (br_valid || !instr_ready || instr_valid) idle = 0;
            else idle++;
            n_cmp++;
            if (idle > 2) begin
                n_bad++;
                $display("FAIL rand_starve c=%0d: got %0d idle ready cycles, want at most 2", c, idle);
            end
            prev_hold  = instr_valid && !instr_ready && !br_valid;
            prev_instr = instr;
            prev_pc    = instr_pc;
            prev_br    = br_valid;
            if (br_valid) exp_pc = br_target;
            next_cycle();
        end
        br_valid    = 1'b0;
        instr_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
